// File: rtl/darkmac_pkg.sv
// darkmac_pkg: operation encodings and lane/product/sum width helpers shared
// by the darkmac pipeline, its dot-product unit and its bus interface.
package darkmac_pkg;

  typedef enum logic [1:0] {
    OP_MAC = 2'b00,
    OP_CLR = 2'b01,
    OP_LD  = 2'b10,
    OP_RD  = 2'b11
  } op_e;

  // Width of one signed sub-word lane.
  function automatic int lane_w(input int xlen, input int lanes);
    return xlen / lanes;
  endfunction

  // Width of one full-precision lane product.
  function automatic int prod_w(input int xlen, input int lanes);
    return 2 * lane_w(xlen, lanes);
  endfunction

  // Width that holds the sum of all lane products without overflow.
  function automatic int sum_w(input int xlen, input int lanes);
    return prod_w(xlen, lanes) + $clog2(lanes);
  endfunction

endpackage

// File: rtl/darkmac_if.sv
// darkmac_if: request/response bus between the core (master) and darkmac
// (slave).
//
// Handshake: a request is taken on a rising clock edge when IVALID && IREADY.
// IREADY is simply !HLT, so the master may hold IVALID and its payload
// (OP, ASEL, S1, S2) until IREADY is seen high. OVALID is a strobe with no
// back-pressure; while HLT is high a pending strobe stays asserted and is
// consumed by the first edge on which HLT is low.
interface darkmac_if import darkmac_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NACC = 4,
  parameter int ACCW = 32
) ();

  localparam int AW = $clog2(NACC);

  logic            HLT;
  logic            IVALID;
  logic            IREADY;
  op_e             OP;
  logic [AW-1:0]   ASEL;
  logic [XLEN-1:0] S1;
  logic [XLEN-1:0] S2;
  logic            OVALID;
  logic [ACCW-1:0] ODATA;
  logic            BUSY;
  logic            OVF;

  modport master (
    output HLT, IVALID, OP, ASEL, S1, S2,
    input  IREADY, OVALID, ODATA, BUSY, OVF
  );

  modport slave (
    input  HLT, IVALID, OP, ASEL, S1, S2,
    output IREADY, OVALID, ODATA, BUSY, OVF
  );

endinterface

// File: rtl/darkmac_dot.sv
// darkmac_dot: splits both operands into signed lanes, registers the lane
// products (this register is the stage-1 boundary of darkmac) and sums the
// registered products combinationally for stage 2.
module darkmac_dot import darkmac_pkg::*; #(
  parameter  int XLEN  = 32,
  parameter  int LANES = 4,
  localparam int LW    = lane_w(XLEN, LANES),
  localparam int PW    = prod_w(XLEN, LANES),
  localparam int SW    = sum_w(XLEN, LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [XLEN-1:0]      a_i,
  input  logic [XLEN-1:0]      b_i,
  output logic signed [SW-1:0] sum_o
);

  logic signed [PW-1:0] prod_d [LANES];
  logic signed [PW-1:0] prod_q [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [LW-1:0] a_l;
    logic signed [LW-1:0] b_l;
    assign a_l = a_i[g*LW +: LW];
    assign b_l = b_i[g*LW +: LW];
    // Both factors are sign-extended to PW, so the PW-bit product is exact.
    assign prod_d[g] = PW'(a_l) * PW'(b_l);
  end

  // Stage-1 product registers; hold when the pipeline is frozen or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (en_i) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
    end
  end

  // Sign-extended summation of the registered lane products.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < LANES; i++) sum_o = sum_o + SW'(prod_q[i]);
  end

endmodule

// File: rtl/darkmac.sv
// darkmac: two-stage packed-SIMD multiply-accumulate unit with NACC
// accumulators. Stage 1 registers lane products and the request; stage 2
// sums them and applies MAC/CLR/LD/RD to the selected accumulator.
// Optional feature: define DARKMAC_SAT_EN to make MAC saturate instead of
// wrapping on signed overflow.
module darkmac import darkmac_pkg::*; #(
  parameter  int XLEN  = 32,
  parameter  int LANES = 4,
  parameter  int NACC  = 4,
  parameter  int ACCW  = 32,
  localparam int AW    = $clog2(NACC),
  localparam int SW    = sum_w(XLEN, LANES)
) (
  input logic      CLK,
  input logic      RES,
  darkmac_if.slave bus
);

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = ~ACC_MAX;

  logic                   advance;
  logic                   s1_valid_q;
  op_e                    s1_op_q;
  logic [AW-1:0]          s1_asel_q;
  logic [XLEN-1:0]        s1_opa_q;
  logic signed [SW-1:0]   dot_sum;
  logic signed [ACCW-1:0] acc_q [NACC];
  logic signed [ACCW-1:0] acc_cur;
  logic signed [ACCW-1:0] dot_ext;
  logic signed [ACCW-1:0] mac_sum;
  logic signed [ACCW-1:0] acc_d;
  logic                   mac_ovf;
  logic                   ovf_d;
  logic                   ovf_q;
  logic                   ovalid_q;
  logic signed [ACCW-1:0] odata_q;

  // HLT freezes every register, so it is also the only source of back-pressure.
  assign advance    = !bus.HLT;
  assign bus.IREADY = advance;

  darkmac_dot #(.XLEN(XLEN), .LANES(LANES)) u_dot (
    .clk   (CLK),
    .rst   (RES),
    .en_i  (advance && bus.IVALID),
    .a_i   (bus.S1),
    .b_i   (bus.S2),
    .sum_o (dot_sum)
  );

  // Stage-1 request register; an idle slot shifts in a bubble.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_RD;
      s1_asel_q  <= '0;
      s1_opa_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= bus.IVALID;
      if (bus.IVALID) begin
        s1_op_q   <= bus.OP;
        s1_asel_q <= bus.ASEL;
        s1_opa_q  <= bus.S1;
      end
    end
  end

  // Stage-2 next value of the selected accumulator and of the sticky flag.
  // The accumulator is read and written only here, so back-to-back ops on the
  // same accumulator always see the previous result.
  always_comb begin
    acc_cur = acc_q[s1_asel_q];
    dot_ext = ACCW'(dot_sum);
    mac_sum = acc_cur + dot_ext;
    mac_ovf = (acc_cur[ACCW-1] == dot_ext[ACCW-1]) &&
              (mac_sum[ACCW-1] != acc_cur[ACCW-1]);
    acc_d   = acc_cur;
    ovf_d   = ovf_q;
    unique case (s1_op_q)
      OP_MAC: begin
`ifdef DARKMAC_SAT_EN
        if (mac_ovf) acc_d = acc_cur[ACCW-1] ? ACC_MIN : ACC_MAX;
        else         acc_d = mac_sum;
`else
        acc_d = mac_sum;
`endif
        if (mac_ovf) ovf_d = 1'b1;
      end
      OP_CLR: begin
        acc_d = '0;
        ovf_d = 1'b0;
      end
      OP_LD:   acc_d = ACCW'($signed(s1_opa_q));
      default: acc_d = acc_cur;
    endcase
  end

  // Stage-2 registers: accumulator write-back, result strobe/data, OVF.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (advance) begin
      ovalid_q <= s1_valid_q;
      if (s1_valid_q) begin
        acc_q[s1_asel_q] <= acc_d;
        odata_q          <= acc_d;
        ovf_q            <= ovf_d;
      end
    end
  end

  assign bus.OVALID = ovalid_q;
  assign bus.ODATA  = odata_q;
  assign bus.BUSY   = s1_valid_q || ovalid_q;
  assign bus.OVF    = ovf_q;

endmodule

// File: tb/tb_darkmac.sv
// tb_darkmac: directed scoreboard bench for darkmac (XLEN=32, LANES=4,
// NACC=4, ACCW=32). Inputs change 1 time unit after each falling edge;
// the monitor samples on falling edges.
module tb_darkmac;
  import darkmac_pkg::*;

  localparam int XLEN  = 32;
  localparam int LANES = 4;
  localparam int NACC  = 4;
  localparam int ACCW  = 32;
  localparam int AW    = $clog2(NACC);

`ifdef DARKMAC_SAT_EN
  localparam logic [ACCW-1:0] EXP_A3 = 32'h7FFF_FFFF;
`else
  localparam logic [ACCW-1:0] EXP_A3 = 32'h8000_FBF4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [ACCW-1:0] exp_q[$];
  logic            exp_ovf_q[$];
  int              exp_cyc_q[$];

  logic [ACCW-1:0] mon_d;
  logic            mon_o;
  int              mon_c;

  darkmac_if #(.XLEN(XLEN), .NACC(NACC), .ACCW(ACCW)) bus ();

  darkmac #(.XLEN(XLEN), .LANES(LANES), .NACC(NACC), .ACCW(ACCW)) dut (
    .CLK (clk),
    .RES (rst),
    .bus (bus.slave)
  );

  // ---- clock / reset block ----
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---- driver tasks ----
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present one request for one cycle; optionally queue its expected result,
  // which must appear 2 cycles (+ extra halted cycles) after presentation.
  task automatic issue(input op_e op, input logic [AW-1:0] asel,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input bit push, input logic [ACCW-1:0] ed,
                       input logic eo, input int extra);
    bus.IVALID = 1'b1;
    bus.OP     = op;
    bus.ASEL   = asel;
    bus.S1     = a;
    bus.S2     = b;
    if (push) begin
      exp_q.push_back(ed);
      exp_ovf_q.push_back(eo);
      exp_cyc_q.push_back(cyc + 2 + extra);
    end
    step();
  endtask

  task automatic idle(input int n);
    bus.IVALID = 1'b0;
    repeat (n) step();
  endtask

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    if (!rst && bus.OVALID && !bus.HLT) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual ODATA=0x%0h expected no strobe (cycle %0d)",
                 bus.ODATA, cyc);
      end else begin
        mon_d = exp_q.pop_front();
        mon_o = exp_ovf_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("odata", bus.ODATA, mon_d);
        check("ovf", bus.OVF, mon_o);
        check("strobe_cycle", cyc, mon_c);
      end
    end
  end

  // ---- stimulus ----
  initial begin
    bus.HLT    = 1'b0;
    bus.IVALID = 1'b0;
    bus.OP     = OP_RD;
    bus.ASEL   = '0;
    bus.S1     = '0;
    bus.S2     = '0;
    rst        = 1'b1;
    repeat (2) step();

    check("rst_ovalid", bus.OVALID, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_odata", bus.ODATA, 0);
    check("rst_ovf", bus.OVF, 0);
    check("rst_iready", bus.IREADY, 1);
    rst = 1'b0;
    step();

    // Basic dot products: 1+2+3+4 = 10 and 4 * (-1 * 2) = -8.
    issue(OP_CLR, 2'd0, 32'h0, 32'h0, 1, 32'h0, 1'b0, 0);
    issue(OP_MAC, 2'd0, 32'h0102_0304, 32'h0101_0101, 1, 32'h0000_000A, 1'b0, 0);
    issue(OP_CLR, 2'd1, 32'h0, 32'h0, 1, 32'h0, 1'b0, 0);
    issue(OP_MAC, 2'd1, 32'hFFFF_FFFF, 32'h0202_0202, 1, 32'hFFFF_FFF8, 1'b0, 0);

    // Back-to-back accumulation on one accumulator.
    issue(OP_CLR, 2'd2, 32'h0, 32'h0, 1, 32'h0, 1'b0, 0);
    issue(OP_MAC, 2'd2, 32'h0102_0304, 32'h0101_0101, 1, 32'd10, 1'b0, 0);
    issue(OP_MAC, 2'd2, 32'h0102_0304, 32'h0101_0101, 1, 32'd20, 1'b0, 0);
    issue(OP_MAC, 2'd2, 32'h0102_0304, 32'h0101_0101, 1, 32'd30, 1'b0, 0);
    idle(3);

    // Overflow: 0x7FFFFFF0 + 4*127*127 (0xFC04); OVF is sticky until a CLR.
    issue(OP_LD,  2'd3, 32'h7FFF_FFF0, 32'h0, 1, 32'h7FFF_FFF0, 1'b0, 0);
    issue(OP_MAC, 2'd3, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 1, EXP_A3, 1'b1, 0);
    issue(OP_RD,  2'd3, 32'h0, 32'h0, 1, EXP_A3, 1'b1, 0);
    issue(OP_CLR, 2'd0, 32'h0, 32'h0, 1, 32'h0, 1'b0, 0);
    issue(OP_RD,  2'd3, 32'h0, 32'h0, 1, EXP_A3, 1'b0, 0);
    idle(3);
    check("ovf_after_clr", bus.OVF, 0);
    check("busy_idle", bus.BUSY, 0);

    // Halt for 3 cycles right after a MAC is accepted.
    issue(OP_MAC, 2'd0, 32'h0102_0304, 32'h0101_0101, 1, 32'd10, 1'b0, 3);
    bus.IVALID = 1'b0;
    bus.HLT    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("iready_halt", bus.IREADY, 0);
      check("ovalid_halt", bus.OVALID, 0);
      check("busy_halt", bus.BUSY, 1);
      step();
    end
    bus.HLT = 1'b0;
    idle(4);

    // Reset one cycle after a MAC is accepted: the MAC must vanish.
    issue(OP_MAC, 2'd1, 32'h0102_0304, 32'h0101_0101, 0, 32'h0, 1'b0, 0);
    bus.IVALID = 1'b0;
    rst        = 1'b1;
    step();
    check("midrst_ovalid", bus.OVALID, 0);
    check("midrst_busy", bus.BUSY, 0);
    check("midrst_odata", bus.ODATA, 0);
    rst = 1'b0;
    step();
    for (int a = 0; a < NACC; a++) begin
      issue(OP_RD, AW'(a), 32'h0, 32'h0, 1, 32'h0, 1'b0, 0);
    end
    idle(5);

    check("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
